// File: rtl/apple_gen.sv
// Apple placement generator: relocates the apple to a random in-arena pixel on request.
// Optional build macro APPLE_AVOID_HEAD_EN rejects a candidate that lands on the snake head.
module apple_gen #(
  parameter int          H_RES     = 1280,
  parameter int          V_RES     = 720,
  parameter int          RED_WALL  = 30,
  parameter int          APPLE_X0  = 960,
  parameter int          APPLE_Y0  = 360,
  parameter int          MAX_TRIES = 15,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        apple_refresh,
  input  logic [1:0]  game_status,
  input  logic [11:0] snake_head_x,
  input  logic [11:0] snake_head_y,
  output logic [11:0] apple_x,
  output logic [11:0] apple_y,
  output logic        apple_busy
);

  typedef enum logic [1:0] {IDLE, PICK_X, PICK_Y, COMMIT} state_t;

  localparam logic [11:0] X_LO      = 12'(RED_WALL);
  localparam logic [11:0] X_HI      = 12'(H_RES - RED_WALL);
  localparam logic [11:0] Y_LO      = 12'(RED_WALL);
  localparam logic [11:0] Y_HI      = 12'(V_RES - RED_WALL);
  localparam logic [11:0] X_FALL    = 12'(H_RES / 4);
  localparam logic [11:0] Y_FALL    = 12'(V_RES / 4);
  localparam logic [11:0] X_START   = 12'(APPLE_X0);
  localparam logic [11:0] Y_START   = 12'(APPLE_Y0);
  localparam logic [3:0]  TRY_LIMIT = 4'(MAX_TRIES);
  localparam logic [1:0]  RESTART   = 2'b10;

  state_t      state;
  state_t      next_state;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic [3:0]  tries;
  logic [3:0]  tries_next;
  logic [11:0] cand_x;
  logic [11:0] cand_y;
  logic [11:0] cand_x_next;
  logic [11:0] cand_y_next;
  logic [11:0] draw_x;
  logic [11:0] draw_y;
  logic        x_ok;
  logic        y_in_window;
  logic        y_ok;
  logic        restart;
  logic        commit;

  assign restart = (game_status == RESTART);

  // Fibonacci LFSR, x^16+x^14+x^13+x^11+1; never reseeded on restart so games differ
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_next;
    end
  end

  assign draw_x      = {1'b0, lfsr[10:0]};
  assign draw_y      = {2'b00, lfsr[9:0]};
  assign x_ok        = (draw_x > X_LO) && (draw_x < X_HI);
  assign y_in_window = (draw_y > Y_LO) && (draw_y < Y_HI);

`ifdef APPLE_AVOID_HEAD_EN
  assign y_ok = y_in_window && !((cand_x == snake_head_x) && (draw_y == snake_head_y));
`else
  logic unused_head;
  assign unused_head = ^{snake_head_x, snake_head_y};
  assign y_ok        = y_in_window;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    tries_next  = tries;
    cand_x_next = cand_x;
    cand_y_next = cand_y;
    if (restart) begin
      next_state = IDLE;
      tries_next = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (apple_refresh) begin
            next_state = PICK_X;
            tries_next = 4'd0;
          end
        end
        PICK_X: begin
          if (x_ok) begin
            cand_x_next = draw_x;
            tries_next  = 4'd0;
            next_state  = PICK_Y;
          end else if (tries == TRY_LIMIT) begin
            cand_x_next = X_FALL;
            tries_next  = 4'd0;
            next_state  = PICK_Y;
          end else begin
            tries_next = tries + 4'd1;
          end
        end
        PICK_Y: begin
          if (y_ok) begin
            cand_y_next = draw_y;
            tries_next  = 4'd0;
            next_state  = COMMIT;
          end else if (tries == TRY_LIMIT) begin
            cand_y_next = Y_FALL;
            tries_next  = 4'd0;
            next_state  = COMMIT;
          end else begin
            tries_next = tries + 4'd1;
          end
        end
        COMMIT: begin
          next_state = IDLE;
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    apple_busy = (state != IDLE);
    commit     = (state == COMMIT) && !restart;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tries  <= 4'd0;
      cand_x <= X_START;
      cand_y <= Y_START;
    end else begin
      tries  <= tries_next;
      cand_x <= cand_x_next;
      cand_y <= cand_y_next;
    end
  end

  // Published coordinates only move on COMMIT, so a reader never sees a half-updated pair
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      apple_x <= X_START;
      apple_y <= Y_START;
    end else if (restart) begin
      apple_x <= X_START;
      apple_y <= Y_START;
    end else if (commit) begin
      apple_x <= cand_x;
      apple_y <= cand_y;
    end
  end

endmodule

// File: tb/tb_apple_gen.sv
// Directed self-checking bench for apple_gen: reset, relocation timing, fallback,
// back-to-back requests, restart abort, head avoidance and asynchronous reset.
module tb_apple_gen;

`ifdef APPLE_AVOID_HEAD_EN
  localparam bit AVOID = 1'b1;
`else
  localparam bit AVOID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        apple_refresh = 1'b0;
  logic        refresh2 = 1'b0;
  logic [1:0]  game_status = 2'b00;
  logic [11:0] head_x = 12'd0;
  logic [11:0] head_y = 12'd0;
  logic [11:0] apple_x;
  logic [11:0] apple_y;
  logic        apple_busy;
  logic [11:0] apple_x2;
  logic [11:0] apple_y2;
  logic        apple_busy2;

  int checks = 0;
  int failures = 0;

  logic [15:0] lfsr_m;

  apple_gen dut (
    .clk(clk), .rst(rst), .apple_refresh(apple_refresh), .game_status(game_status),
    .snake_head_x(head_x), .snake_head_y(head_y),
    .apple_x(apple_x), .apple_y(apple_y), .apple_busy(apple_busy)
  );

  // Empty legal window on both axes, so every search must end on the fallback point
  apple_gen #(.RED_WALL(640)) dut_wall (
    .clk(clk), .rst(rst), .apple_refresh(refresh2), .game_status(game_status),
    .snake_head_x(head_x), .snake_head_y(head_y),
    .apple_x(apple_x2), .apple_y(apple_y2), .apple_busy(apple_busy2)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= lfsr_step(lfsr_m);
  end

  // Reference search: start is the LFSR value seen by the first PICK_X cycle
  task automatic predict(input logic [15:0] start, input bit avoid,
                         input logic [11:0] hx, input logic [11:0] hy,
                         output logic [11:0] px, output logic [11:0] py,
                         output int nx, output int ny);
    logic [15:0] l;
    logic [11:0] c;
    l  = start;
    px = 12'd320;
    py = 12'd180;
    nx = 0;
    ny = 0;
    for (int k = 0; k < 16; k++) begin
      nx++;
      c = {1'b0, l[10:0]};
      l = lfsr_step(l);
      if (c > 12'd30 && c < 12'd1250) begin
        px = c;
        break;
      end
    end
    for (int k = 0; k < 16; k++) begin
      ny++;
      c = {2'b00, l[9:0]};
      l = lfsr_step(l);
      if (c > 12'd30 && c < 12'd690 && !(avoid && px == hx && c == hy)) begin
        py = c;
        break;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit refresh, input logic [1:0] status);
    apple_refresh = refresh;
    game_status   = status;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic relocateAndCheck(input string tag);
    logic [11:0] px, py, old_x, old_y;
    int nx, ny;
    old_x = apple_x;
    old_y = apple_y;
    applyStimulus(1'b1, 2'b00);
    tick();
    applyStimulus(1'b0, 2'b00);
    checkOutput({tag, "_busy_rise"}, 32'(apple_busy), 32'd1);
    predict(lfsr_m, AVOID, head_x, head_y, px, py, nx, ny);
    repeat (nx + ny) tick();
    checkOutput({tag, "_hold_x"}, 32'(apple_x), 32'(old_x));
    checkOutput({tag, "_hold_y"}, 32'(apple_y), 32'(old_y));
    checkOutput({tag, "_busy_mid"}, 32'(apple_busy), 32'd1);
    tick();
    checkOutput({tag, "_x"}, 32'(apple_x), 32'(px));
    checkOutput({tag, "_y"}, 32'(apple_y), 32'(py));
    checkOutput({tag, "_busy_fall"}, 32'(apple_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [11:0] px, py, px0, py0, prev_x, prev_y;
    logic prev_busy;
    int nx, ny, relocs, wait_cycles;

    // Reset held for three cycles, released between edges
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_x", 32'(apple_x), 32'd960);
    checkOutput("reset_y", 32'(apple_y), 32'd360);
    checkOutput("reset_busy", 32'(apple_busy), 32'd0);
    checkOutput("reset_lfsr", 32'(dut.lfsr), 32'hACE1);
    tick();

    // Single-pulse relocations against the reference model
    relocateAndCheck("reloc1");
    checkOutput("reloc1_x_window", 32'(apple_x > 12'd30 && apple_x < 12'd1250), 32'd1);
    checkOutput("reloc1_y_window", 32'(apple_y > 12'd30 && apple_y < 12'd690), 32'd1);
    repeat (7) tick();
    relocateAndCheck("reloc2");
    repeat (3) tick();
    relocateAndCheck("reloc3");

    // Worst case: every draw rejected, fallback after 16 draws per axis
    refresh2 = 1'b1;
    tick();
    refresh2 = 1'b0;
    checkOutput("fallback_busy_rise", 32'(apple_busy2), 32'd1);
    repeat (32) tick();
    checkOutput("fallback_busy_mid", 32'(apple_busy2), 32'd1);
    checkOutput("fallback_hold_x", 32'(apple_x2), 32'd960);
    tick();
    checkOutput("fallback_x", 32'(apple_x2), 32'd320);
    checkOutput("fallback_y", 32'(apple_y2), 32'd180);
    checkOutput("fallback_busy_fall", 32'(apple_busy2), 32'd0);

    // Refresh held high: back-to-back searches, coordinates always legal
    applyStimulus(1'b1, 2'b00);
    prev_x = apple_x;
    prev_y = apple_y;
    prev_busy = apple_busy;
    relocs = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      checkOutput("held_x_window", 32'(apple_x > 12'd30 && apple_x < 12'd1250), 32'd1);
      checkOutput("held_y_window", 32'(apple_y > 12'd30 && apple_y < 12'd690), 32'd1);
      if (apple_x != prev_x || apple_y != prev_y) begin
        relocs++;
        checkOutput("held_update_on_commit", 32'(prev_busy && !apple_busy), 32'd1);
      end
      prev_x = apple_x;
      prev_y = apple_y;
      prev_busy = apple_busy;
    end
    checkOutput("held_relocations", 32'(relocs >= 5), 32'd1);
    applyStimulus(1'b0, 2'b00);
    wait_cycles = 0;
    while (apple_busy && wait_cycles < 40) begin
      tick();
      wait_cycles++;
    end
    checkOutput("held_drain", 32'(apple_busy), 32'd0);
    tick();

    // Restart while in PICK_Y aborts the search
    checkOutput("pre_restart_moved", 32'(apple_x != 12'd960 || apple_y != 12'd360), 32'd1);
    applyStimulus(1'b1, 2'b00);
    tick();
    applyStimulus(1'b0, 2'b00);
    predict(lfsr_m, AVOID, head_x, head_y, px, py, nx, ny);
    repeat (nx) tick();
    checkOutput("pre_restart_busy", 32'(apple_busy), 32'd1);
    applyStimulus(1'b0, 2'b10);
    tick();
    checkOutput("restart_x", 32'(apple_x), 32'd960);
    checkOutput("restart_y", 32'(apple_y), 32'd360);
    checkOutput("restart_busy", 32'(apple_busy), 32'd0);
    checkOutput("restart_state_idle", 32'(dut.state), 32'd0);
    applyStimulus(1'b0, 2'b00);
    repeat (40) tick();
    checkOutput("restart_no_commit_x", 32'(apple_x), 32'd960);
    checkOutput("restart_no_commit_busy", 32'(apple_busy), 32'd0);

    // Head placed on the first legal pair the model draws
    applyStimulus(1'b1, 2'b00);
    tick();
    applyStimulus(1'b0, 2'b00);
    predict(lfsr_m, 1'b0, 12'd0, 12'd0, px0, py0, nx, ny);
    head_x = px0;
    head_y = py0;
    predict(lfsr_m, AVOID, head_x, head_y, px, py, nx, ny);
    repeat (nx + ny) tick();
    checkOutput("head_busy_mid", 32'(apple_busy), 32'd1);
    tick();
    checkOutput("head_x", 32'(apple_x), 32'(px));
    checkOutput("head_y", 32'(apple_y), 32'(py));
`ifdef APPLE_AVOID_HEAD_EN
    checkOutput("head_avoided", 32'(apple_x != head_x || apple_y != head_y), 32'd1);
`else
    checkOutput("head_allowed", 32'(apple_x == head_x && apple_y == head_y), 32'd1);
`endif
    tick();

    // Asynchronous reset in the middle of PICK_X
    applyStimulus(1'b1, 2'b00);
    tick();
    applyStimulus(1'b0, 2'b00);
    checkOutput("pre_rst_busy", 32'(apple_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_x", 32'(apple_x), 32'd960);
    checkOutput("async_rst_y", 32'(apple_y), 32'd360);
    checkOutput("async_rst_busy", 32'(apple_busy), 32'd0);
    checkOutput("async_rst_lfsr", 32'(dut.lfsr), 32'hACE1);
    #3 rst = 1'b0;
    repeat (5) tick();
    checkOutput("post_rst_busy", 32'(apple_busy), 32'd0);
    checkOutput("post_rst_x", 32'(apple_x), 32'd960);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
